// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: widths,
// grant-source encoding, the writeback request record and a register
// mask helper that never selects register 0.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Which writeback source won the most recent accepted transfer.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    // One writeback request: valid, destination register and value.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // One-hot mask for a register; register 0 yields an empty mask so it
    // is never tracked as pending.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant between the ALU and load writeback sources.
// Grants are combinational; the last-granted pointer is the only state.
// Handshake: a request is accepted in a cycle where its request and its
// grant are both high; at most one grant is high, and none during reset.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_alu,
    input  logic    i_req_mem,
    output logic    o_gnt_alu,
    output logic    o_gnt_mem,
    output wb_src_t o_last_grant
);

    wb_src_t r_last;

    // Lone requester wins outright; on contention the source not granted last wins.
    always_comb begin
        o_gnt_alu = 1'b0;
        o_gnt_mem = 1'b0;
        if (rst_n) begin
            if (i_req_mem && (!i_req_alu || r_last == SRC_ALU)) begin
                o_gnt_mem = 1'b1;
            end else if (i_req_alu) begin
                o_gnt_alu = 1'b1;
            end
        end
    end

    // Pointer moves only when a transfer is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC_ALU;
        end else if (o_gnt_mem) begin
            r_last <= SRC_MEM;
        end else if (o_gnt_alu) begin
            r_last <= SRC_ALU;
        end
    end

    assign o_last_grant = r_last;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks onto a
// single registered write port, and (when REGFILE_WB_SCOREBOARD_EN is
// defined) tracks pending destinations to stall hazardous issues.
// Handshake: a source transfers in a cycle where its valid and ready are
// both 1; ready depends combinationally on valid and is never raised for
// two sources at once.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    output logic                  issue_stall
);

    wb_req_t w_alu_req;
    wb_req_t w_mem_req;
    wb_req_t w_sel;
    logic    w_gnt_alu;
    logic    w_gnt_mem;
    logic    w_accept;
    wb_src_t w_last_grant;

    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;

    assign w_alu_req = '{valid: alu_valid, dest: alu_reg, data: alu_data};
    assign w_mem_req = '{valid: mem_valid, dest: mem_reg, data: mem_data};

    wb_rr_arbiter u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_alu    (w_alu_req.valid),
        .i_req_mem    (w_mem_req.valid),
        .o_gnt_alu    (w_gnt_alu),
        .o_gnt_mem    (w_gnt_mem),
        .o_last_grant (w_last_grant)
    );

    assign alu_ready = w_gnt_alu;
    assign mem_ready = w_gnt_mem;

    // Select the granted request; valid stays low when nothing is granted.
    always_comb begin
        w_sel = w_gnt_mem ? w_mem_req : w_alu_req;
        if (!(w_gnt_alu || w_gnt_mem)) begin
            w_sel.valid = 1'b0;
        end
    end

    assign w_accept = w_sel.valid;

    // Register the accepted write; writes to register 0 are swallowed and
    // the last address/value is held whenever no write is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_accept && w_sel.dest != '0) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= w_sel.dest;
            r_write_data <= w_sel.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                w_stall;

    // Hazard check uses the pending bits as they stood at the start of the cycle.
    always_comb begin
        w_stall    = issue_valid &&
                     ((r_pending & (reg_mask(issue_rs) | reg_mask(issue_rt) |
                                    reg_mask(issue_dest))) != '0);
        w_set_mask = (issue_valid && !w_stall) ? reg_mask(issue_dest) : '0;
        w_clr_mask = w_accept ? reg_mask(w_sel.dest) : '0;
    end

    // Clear on writeback, then set on issue, so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign issue_stall = w_stall;
`else
    logic w_unused_issue;
    assign w_unused_issue = &{1'b0, issue_valid, issue_dest, issue_rs, issue_rt};
    assign issue_stall    = 1'b0;
`endif

    logic w_unused_last;
    assign w_unused_last = &{1'b0, w_last_grant};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed
// by random traffic, all compared against a behavioural model. Stall
// expectations follow REGFILE_WB_SCOREBOARD_EN as seen by this file.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_reg, mem_reg, write_reg;
    logic [31:0] alu_data, mem_data, write_data;
    logic        reg_write;
    logic        issue_valid, issue_stall;
    logic [4:0]  issue_dest, issue_rs, issue_rt;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_rs    (issue_rs),
        .issue_rt    (issue_rt),
        .issue_stall (issue_stall)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [36:0] exp_q[$];          // {reg, data} of writes due next cycle
    bit          m_last_mem;        // 1 when MEM won the last accepted transfer
    bit          m_pend[32];        // registers with an outstanding result
    logic [31:0] m_hold_data;       // value write_data must hold when idle

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_last_mem  = 1'b0;
        m_hold_data = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                          input bit mv, input logic [4:0] mr, input logic [31:0] md,
                          input bit iv, input logic [4:0] idst, input logic [4:0] irs,
                          input logic [4:0] irt);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        issue_valid = iv; issue_dest = idst; issue_rs = irs; issue_rt = irt;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called just after a falling edge with inputs applied; checks this
    // cycle's outputs, advances the model across the rising edge and
    // returns at the next falling edge.
    task automatic check_cycle();
        bit          g_alu, g_mem, e_stall;
        logic [36:0] e;
        logic [4:0]  d;
        logic [31:0] dat;
        bit          nxt[32];
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("reg_write", reg_write, 1);
            chk("write_reg", write_reg, e[36:32]);
            chk("write_data", write_data, e[31:0]);
            m_hold_data = e[31:0];
        end else begin
            chk("reg_write_idle", reg_write, 0);
            chk("write_data_hold", write_data, m_hold_data);
        end
        if (!rst_n) chk("rst_write_reg", write_reg, 0);

        g_alu = 1'b0;
        g_mem = 1'b0;
        if (rst_n) begin
            if (alu_valid && mem_valid) begin
                g_mem = !m_last_mem;
                g_alu = m_last_mem;
            end else begin
                g_mem = mem_valid;
                g_alu = alu_valid;
            end
        end
        chk("alu_ready", alu_ready, g_alu);
        chk("mem_ready", mem_ready, g_mem);

        e_stall = SB_EN && issue_valid &&
                  ((issue_rs   != 0 && m_pend[issue_rs])  ||
                   (issue_rt   != 0 && m_pend[issue_rt])  ||
                   (issue_dest != 0 && m_pend[issue_dest]));
        chk("issue_stall", issue_stall, e_stall);

        d   = g_mem ? mem_reg  : alu_reg;
        dat = g_mem ? mem_data : alu_data;
        for (int i = 0; i < 32; i++) nxt[i] = m_pend[i];
        if ((g_alu || g_mem) && d != 0) nxt[d] = 1'b0;
        if (issue_valid && !e_stall && issue_dest != 0) nxt[issue_dest] = 1'b1;

        @(posedge clk);
        if (rst_n) begin
            if (g_alu || g_mem) begin
                m_last_mem = g_mem;
                if (d != 0) exp_q.push_back({d, dat});
            end
            for (int i = 0; i < 32; i++) m_pend[i] = nxt[i];
        end else begin
            reset_model();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_in();
        reset_model();
        @(negedge clk);
        check_cycle();
        check_cycle();
        rst_n = 1'b1;

        // Contention straight after reset: MEM, ALU, MEM.
        set_in(1, 5'd1, 32'hAAAA_0001, 1, 5'd2, 32'hBBBB_0002, 0, 0, 0, 0);
        #1 chk("rr1_mem_ready", mem_ready, 1);
        check_cycle();
        #1 chk("rr2_alu_ready", alu_ready, 1);
        check_cycle();
        chk("rr2_write_reg", write_reg, 5'd1);
        #1 chk("rr3_mem_ready", mem_ready, 1);
        check_cycle();
        chk("rr3_write_reg", write_reg, 5'd2);
        idle_in();
        check_cycle();

        // Lone ALU write.
        set_in(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("alu_lone_ready", alu_ready, 1);
        check_cycle();
        chk("alu_lone_we", reg_write, 1);
        chk("alu_lone_reg", write_reg, 5'd5);
        chk("alu_lone_data", write_data, 32'hDEAD_BEEF);
        idle_in();

        // Load to register 0: accepted but no write.
        set_in(0, 0, 0, 1, 5'd0, 32'h0000_1234, 0, 0, 0, 0);
        #1 chk("r0_mem_ready", mem_ready, 1);
        check_cycle();
        chk("r0_no_write", reg_write, 0);
        chk("r0_data_held", write_data, 32'hDEAD_BEEF);
        idle_in();
        check_cycle();

        // Issue dest 7, then a reader of r7 stalls until r7 is written back.
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0);
        check_cycle();
        set_in(1, 5'd7, 32'h7777_7777, 0, 0, 0, 1, 5'd0, 5'd7, 5'd0);
        #1 chk("raw7_stall", issue_stall, SB_EN);
        check_cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd7, 5'd0);
        #1 chk("raw7_released", issue_stall, 0);
        check_cycle();

        // Same-cycle issue dest 9 and writeback to r9: r9 stays pending.
        set_in(1, 5'd9, 32'h9999_0000, 0, 0, 0, 1, 5'd9, 5'd0, 5'd0);
        check_cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd9);
        #1 chk("set_wins9_stall", issue_stall, SB_EN);
        check_cycle();
        set_in(0, 0, 0, 1, 5'd9, 32'h9999_1111, 0, 0, 0, 0);
        check_cycle();

        // Mark r11 pending, then reset during an accepted ALU transfer.
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd0, 5'd0);
        check_cycle();
        set_in(1, 5'd3, 32'h3333_3333, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("rst_alu_ready_pre", alu_ready, 1);
        #1 rst_n = 1'b0;
        reset_model();
        check_cycle();
        check_cycle();
        rst_n = 1'b1;
        idle_in();
        check_cycle();
        chk("rst_no_write", reg_write, 0);
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd11, 5'd0);
        #1 chk("rst_sb_clear", issue_stall, 0);
        check_cycle();
        idle_in();
        check_cycle();

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            check_cycle();
        end
        idle_in();
        check_cycle();
        check_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
